// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared widths, state encoding and clog2 helper for the debounce scheduler
package debounce_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int CHANNELS_DEFAULT     = 4;
  localparam int NOISE_PERIOD_DEFAULT = 256;
  localparam int CW = clog2(NOISE_PERIOD_DEFAULT);
  localparam int IW = clog2(CHANNELS_DEFAULT);

  typedef enum logic {
    STATE_IDLE     = 1'b0,
    STATE_CHANGING = 1'b1
  } chg_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for raw asynchronous inputs
module sync_2ff #(
  parameter int   WIDTH       = 1,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= {WIDTH{RESET_VALUE}};
      q    <= {WIDTH{RESET_VALUE}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - one debounce engine time-shared round-robin across all channels
// Channel state lives in register arrays; committed edges leave through a single-entry event slot.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int   CHANNELS     = 4,
  parameter int   NOISE_PERIOD = 256,
  parameter logic RESET_VALUE  = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [CHANNELS-1:0]         data_i,
  output logic [CHANNELS-1:0]         data_o,
  output logic                        event_valid,
  input  logic                        event_ready,
  output logic [clog2(CHANNELS)-1:0]  event_channel,
  output logic                        event_rise
);

  localparam int PTR_W = clog2(CHANNELS);
  localparam int CNT_W = clog2(NOISE_PERIOD);
  localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NOISE_PERIOD - 1);

  logic [CHANNELS-1:0] s;
  logic [PTR_W-1:0]    ptr;
  chg_state_t          chg_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];

  logic             cur_s;
  logic             cur_stable;
  chg_state_t       cur_chg;
  logic [CNT_W-1:0] cur_cnt;
  chg_state_t       nxt_chg;
  logic [CNT_W-1:0] nxt_cnt;
  logic             commit;
  logic             slot_free;

  sync_2ff #(
    .WIDTH       (CHANNELS),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (data_i),
    .q     (s)
  );

  assign cur_s      = s[ptr];
  assign cur_stable = data_o[ptr];
  assign cur_chg    = chg_q[ptr];
  assign cur_cnt    = cnt_q[ptr];
  assign slot_free  = !event_valid || event_ready;

  // State register: only the channel under the pointer is written on a tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      data_o <= {CHANNELS{RESET_VALUE}};
      for (int i = 0; i < CHANNELS; i++) begin
        chg_q[i] <= STATE_IDLE;
        cnt_q[i] <= '0;
      end
    end else if (enable) begin
      chg_q[ptr] <= nxt_chg;
      cnt_q[ptr] <= nxt_cnt;
      if (commit) data_o[ptr] <= cur_s;
      ptr <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
    end
  end

  // Next-state for the serviced channel.
  always_comb begin
    nxt_chg = cur_chg;
    nxt_cnt = cur_cnt;
    case (cur_chg)
      STATE_IDLE: begin
        if (cur_s != cur_stable) begin
          nxt_chg = STATE_CHANGING;
          nxt_cnt = '0;
        end
      end
      STATE_CHANGING: begin
        if (cur_s == cur_stable) begin
          nxt_chg = STATE_IDLE;
        end else if (cur_cnt == LAST_CNT) begin
          // A blocked commit parks at the terminal count and retries on the next visit.
          if (slot_free) begin
            nxt_chg = STATE_IDLE;
            nxt_cnt = '0;
          end
        end else begin
          nxt_cnt = cur_cnt + 1'b1;
        end
      end
      default: nxt_chg = STATE_IDLE;
    endcase
  end

  // Output decode: a commit needs a stable new level at terminal count and a free event slot.
  always_comb begin
    commit = 1'b0;
    if (cur_chg == STATE_CHANGING && cur_s != cur_stable && cur_cnt == LAST_CNT && slot_free)
      commit = 1'b1;
  end

  // Event slot: handshake runs every clock, loads happen only on service ticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      event_valid   <= 1'b0;
      event_channel <= '0;
      event_rise    <= 1'b0;
    end else if (enable && commit) begin
      event_valid   <= 1'b1;
      event_channel <= ptr;
      event_rise    <= cur_s;
    end else if (event_ready) begin
      event_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - directed vector bench for debounce_scheduler (4 channels, period 4)
module tb_debounce_scheduler;

  typedef struct {
    logic [3:0] din;
    logic       rdy;
    logic       en;
    int         cycles;
    int         n_ev;
    int         ev_ch;
    int         ev_rise;
    logic [3:0] dout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       event_ready = 1'b0;
  logic [3:0] data_i = 4'b0000;
  logic [3:0] data_o;
  logic       event_valid;
  logic [1:0] event_channel;
  logic       event_rise;

  int n_cmp = 0;
  int n_fail = 0;
  int acc_ch[$];
  int acc_rise[$];
  int ptr_m;
  vec_t vecs[10];

  debounce_scheduler #(
    .CHANNELS     (4),
    .NOISE_PERIOD (4),
    .RESET_VALUE  (1'b0)
  ) dut (
    .clock         (clk),
    .reset         (rst),
    .enable        (enable),
    .data_i        (data_i),
    .data_o        (data_o),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_channel (event_channel),
    .event_rise    (event_rise)
  );

  always #5 clk = ~clk;

  // Channel the next enabled edge will service.
  always @(posedge clk or posedge rst) begin
    if (rst) ptr_m <= 0;
    else if (enable) ptr_m <= (ptr_m == 3) ? 0 : ptr_m + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic collect(input int cycles);
    acc_ch.delete();
    acc_rise.delete();
    for (int k = 0; k < cycles; k++) begin
      if (event_valid && event_ready) begin
        acc_ch.push_back(int'(event_channel));
        acc_rise.push_back(int'(event_rise));
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    data_i      = v.din;
    event_ready = v.rdy;
    enable      = v.en;
    collect(v.cycles);
    chk($sformatf("v%0d_events", idx), acc_ch.size(), v.n_ev);
    if (v.n_ev > 0 && acc_ch.size() > 0) begin
      chk($sformatf("v%0d_channel", idx), acc_ch[0], v.ev_ch);
      chk($sformatf("v%0d_rise", idx), acc_rise[0], v.ev_rise);
    end
    chk($sformatf("v%0d_data_o", idx), int'(data_o), int'(v.dout));
  endtask

  initial begin
    int   found;
    int   seen;
    int   unstable;
    int   changed;
    int   first_ch;
    int   first_rise;

    //              din      rdy   en    cyc n_ev ch rise dout
    vecs[0] = '{4'b0000, 1'b1, 1'b1, 40, 0, 0, 0, 4'b0000};
    vecs[1] = '{4'b0100, 1'b1, 1'b1, 40, 1, 2, 1, 4'b0100};
    vecs[2] = '{4'b0110, 1'b1, 1'b1,  8, 0, 0, 0, 4'b0100};
    vecs[3] = '{4'b0100, 1'b1, 1'b1, 40, 0, 0, 0, 4'b0100};
    vecs[4] = '{4'b0110, 1'b1, 1'b1, 40, 1, 1, 1, 4'b0110};
    vecs[5] = '{4'b0100, 1'b1, 1'b1, 40, 1, 1, 0, 4'b0100};
    vecs[6] = '{4'b1101, 1'b1, 1'b1, 40, 0, 0, 0, 4'b1101};
    vecs[7] = '{4'b1111, 1'b1, 1'b1, 40, 1, 1, 1, 4'b1111};
    vecs[8] = '{4'b1101, 1'b1, 1'b1, 40, 1, 1, 0, 4'b1101};
    vecs[9] = '{4'b0000, 1'b1, 1'b1, 40, 0, 0, 0, 4'b0000};

    repeat (3) @(negedge clk);
    chk("reset_data_o", int'(data_o), 0);
    chk("reset_valid", int'(event_valid), 0);
    rst = 1'b0;
    enable = 1'b1;
    event_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i <= 5; i++) run_vec(i);

    // Backpressure: ch0 and ch3 rise together, ch0 reaches commit first.
    event_ready = 1'b0;
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      if (ptr_m == 2) found = 1;
      else @(negedge clk);
    end
    chk("bp_align", found, 1);
    data_i = 4'b1101;
    seen = 0;
    unstable = 0;
    first_ch = 0;
    first_rise = 0;
    for (int k = 0; k < 40; k++) begin
      if (event_valid) begin
        if (seen == 0) begin
          seen = 1;
          first_ch = int'(event_channel);
          first_rise = int'(event_rise);
        end else if (int'(event_channel) != first_ch || int'(event_rise) != first_rise) begin
          unstable = 1;
        end
      end
      @(negedge clk);
    end
    chk("bp_valid", int'(event_valid), 1);
    chk("bp_channel", int'(event_channel), 0);
    chk("bp_rise", int'(event_rise), 1);
    chk("bp_data_o", int'(data_o), 4'b0101);
    chk("bp_stable", unstable, 0);
    event_ready = 1'b1;
    collect(16);
    chk("bp_accepts", acc_ch.size(), 2);
    if (acc_ch.size() >= 2) begin
      chk("bp_first_ch", acc_ch[0], 0);
      chk("bp_second_ch", acc_ch[1], 3);
      chk("bp_second_rise", acc_rise[1], 1);
    end
    chk("bp_final_data_o", int'(data_o), 4'b1101);

    // Enable held low: inputs toggle, nothing may move.
    enable = 1'b0;
    changed = 0;
    for (int k = 0; k < 100; k++) begin
      data_i = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (data_o != 4'b1101 || event_valid) changed = 1;
    end
    chk("enable_off_hold", changed, 0);
    chk("enable_off_data_o", int'(data_o), 4'b1101);

    for (int i = 6; i <= 8; i++) run_vec(i);

    // Async reset mid-count with an event pending.
    data_i = 4'b1111;
    event_ready = 1'b0;
    collect(40);
    chk("pre_reset_valid", int'(event_valid), 1);
    chk("pre_reset_channel", int'(event_channel), 1);
    data_i = 4'b0000;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_data_o", int'(data_o), 0);
    chk("async_reset_valid", int'(event_valid), 0);
    chk("async_reset_channel", int'(event_channel), 0);
    chk("async_reset_rise", int'(event_rise), 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(9);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
